// File: rtl/mod_pow2_scale.sv
// mod_pow2_scale: computes in_data * 2^in_shift mod q by one modular doubling per clock,
// with valid/ready handshakes on both sides.
module mod_pow2_scale #(
    parameter int LOGQ = 54,
    parameter int LOGS = 6
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [LOGQ-1:0] in_data,
    input  logic [LOGS-1:0] in_shift,
    input  logic [LOGQ-1:0] q,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [LOGQ-1:0] out_data
);
    typedef enum logic [1:0] {IDLE, DOUBLE, DONE} state_t;
    state_t            r_state, w_next;
    logic [LOGQ-1:0]   r_acc, r_q;
    logic [LOGS-1:0]   r_cnt;
    logic [LOGQ:0]     w_t, w_dbl;
    logic              w_accept;
    assign w_t      = {r_acc, 1'b0};
    assign w_dbl    = (w_t >= {1'b0, r_q}) ? w_t - {1'b0, r_q} : w_t;
    // Held low during reset so nothing is accepted while the block is being cleared.
    assign in_ready  = !rst && (r_state == IDLE || (r_state == DONE && out_ready));
    assign w_accept  = in_valid && in_ready;
    assign out_valid = r_state == DONE;
    assign out_data  = out_valid ? r_acc : '0;
    always_comb begin
        w_next = w_accept ? ((in_shift != '0) ? DOUBLE : DONE) :
                 (r_state == DOUBLE && r_cnt == LOGS'(1)) ? DONE :
                 (r_state == DONE && out_ready) ? IDLE : r_state;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_acc   <= '0;
            r_cnt   <= '0;
            r_q     <= '0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_acc <= in_data;
                r_cnt <= in_shift;
                r_q   <= q;
            end else if (r_state == DOUBLE) begin
                r_acc <= w_dbl[LOGQ-1:0];
                r_cnt <= r_cnt - LOGS'(1);
            end
        end
    end
endmodule
